uart_rx32: RTL

- Receive side of the 32-bit UART word link: deserialises four 8N1 bytes from the serial line and assembles them into one 32-bit word.
- Emits the word with a one-cycle valid pulse.
- Mirrors the 32-bit transmitter's framing: first byte on the wire is the most significant byte.
- Sits between the external rx pin and the board/puzzle loading logic.

---
 rtl/uart_rx32.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx32.sv
// uart_rx32: 8N1 receiver that assembles four bytes (MSB first on the wire)
// into a 32-bit word, with frame-error reporting and inter-byte timeout.
module uart_rx32 #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] data,
    output logic        valid,
    output logic        busy,
    output logic        frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int IDLE_MAX     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDLE_W       = $clog2(IDLE_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [23:0]         word_q, word_d;
    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                ferr_q, ferr_d;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idle_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state logic: bit timing, byte assembly, word completion, timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        word_d     = word_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idle_d  = '0;
                end else if (byte_idx_q != 2'd0) begin
                    // A partial word that sits idle too long is dropped silently.
                    if (idle_q == IDLE_LAST) begin
                        byte_idx_d = 2'd0;
                        idle_d     = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        word_d     = {word_q[15:0], shift_q};
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            data_d  = {word_q, shift_q};
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d     = 1'b1;
                        byte_idx_d = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule
